// File: rtl/rsa_wrapper_pkg.sv
// rsa_wrapper_pkg: shared FSM states, default register map and counter sizing for the RSA stream wrapper
package rsa_wrapper_pkg;
  typedef enum logic [2:0] {S_READ_N, S_READ_D, S_READ_C, S_START, S_WAIT, S_SEND} state_t;
  localparam int DEF_RX_ADDR = 0;
  localparam int DEF_TX_ADDR = 4;
  localparam int DEF_STATUS_ADDR = 8;
  localparam int DEF_RX_OK_BIT = 7;
  localparam int DEF_TX_OK_BIT = 6;
  function automatic int cnt_width(input int key_bits);
    return $clog2(key_bits / 8);
  endfunction
endpackage

// File: rtl/avm_byte_port.sv
// avm_byte_port: polls the status register, then reads or writes one data byte over Avalon-MM
module avm_byte_port #(
  parameter int RX_ADDR = 0,
  parameter int TX_ADDR = 4,
  parameter int STATUS_ADDR = 8,
  parameter int RX_OK_BIT = 7,
  parameter int TX_OK_BIT = 6
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic        req,
  input  logic        is_tx,
  input  logic [7:0]  tx_byte,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest,
  output logic        byte_done,
  output logic [7:0]  rx_byte
);
  logic phase_q;
  logic xfer;
  logic ok;
  logic unused;
  assign unused = ^avm_readdata;
  always_comb begin
    ok = is_tx ? avm_readdata[TX_OK_BIT] : avm_readdata[RX_OK_BIT];
    avm_read = req & ~(phase_q & is_tx);
    avm_write = req & phase_q & is_tx;
    avm_address = !phase_q ? 5'(STATUS_ADDR) : is_tx ? 5'(TX_ADDR) : 5'(RX_ADDR);
    avm_writedata = avm_write ? {24'b0, tx_byte} : 32'b0;
    xfer = (avm_read | avm_write) & ~avm_waitrequest;
    byte_done = xfer & phase_q;
    rx_byte = avm_readdata[7:0];
  end
  always_ff @(posedge avm_clk)
    phase_q <= avm_rst ? 1'b0 : xfer ? ~phase_q & ok : phase_q;
endmodule

// File: rtl/rsa_stream_wrapper.sv
// rsa_stream_wrapper: loads N, D and ciphertext byte-serially over Avalon-MM, runs the RSA core and streams the result out
module rsa_stream_wrapper
  import rsa_wrapper_pkg::*;
#(
  parameter int KEY_BITS = 256,
  parameter int KEEP_KEY = 0,
  parameter int RX_ADDR = DEF_RX_ADDR,
  parameter int TX_ADDR = DEF_TX_ADDR,
  parameter int STATUS_ADDR = DEF_STATUS_ADDR,
  parameter int RX_OK_BIT = DEF_RX_OK_BIT,
  parameter int TX_OK_BIT = DEF_TX_OK_BIT
) (
  input  logic                avm_clk,
  input  logic                avm_rst,
  output logic [4:0]          avm_address,
  output logic                avm_read,
  input  logic [31:0]         avm_readdata,
  output logic                avm_write,
  output logic [31:0]         avm_writedata,
  input  logic                avm_waitrequest,
  output logic                o_core_start,
  output logic [KEY_BITS-1:0] o_core_a,
  output logic [KEY_BITS-1:0] o_core_d,
  output logic [KEY_BITS-1:0] o_core_n,
  input  logic [KEY_BITS-1:0] i_core_result,
  input  logic                i_core_finished,
  output logic                o_busy
);
  localparam int NB = KEY_BITS / 8;
  localparam int CW = cnt_width(KEY_BITS);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [KEY_BITS-1:0] n_q, d_q, a_q;
  logic [KEY_BITS-9:0] out_q;
  logic req, is_tx, byte_done, last;
  logic [7:0] rx_byte;
  logic unused;
  assign unused = ^i_core_result[KEY_BITS-1 -: 8];
  assign o_core_n = n_q;
  assign o_core_d = d_q;
  assign o_core_a = a_q;
  avm_byte_port #(
    .RX_ADDR(RX_ADDR), .TX_ADDR(TX_ADDR), .STATUS_ADDR(STATUS_ADDR),
    .RX_OK_BIT(RX_OK_BIT), .TX_OK_BIT(TX_OK_BIT)
  ) u_port (
    .avm_clk(avm_clk), .avm_rst(avm_rst), .req(req), .is_tx(is_tx),
    .tx_byte(out_q[KEY_BITS-9 -: 8]), .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .byte_done(byte_done), .rx_byte(rx_byte)
  );
  always_comb begin
    is_tx = state_q == S_SEND;
    req = is_tx | state_q inside {S_READ_N, S_READ_D, S_READ_C};
    last = cnt_q == (is_tx ? CW'(NB - 2) : CW'(NB - 1));
    o_core_start = state_q == S_START;
    o_busy = state_q inside {S_START, S_WAIT, S_SEND};
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_READ_N: state_d = byte_done && last ? S_READ_D : S_READ_N;
      S_READ_D: state_d = byte_done && last ? S_READ_C : S_READ_D;
      S_READ_C: state_d = byte_done && last ? S_START : S_READ_C;
      S_START:  state_d = S_WAIT;
      S_WAIT:   state_d = i_core_finished ? S_SEND : S_WAIT;
      S_SEND:   state_d = byte_done && last ? (KEEP_KEY != 0 ? S_READ_C : S_READ_N) : S_SEND;
      default:  state_d = S_READ_N;
    endcase
  end
  always_ff @(posedge avm_clk)
    state_q <= avm_rst ? S_READ_N : state_d;
  always_ff @(posedge avm_clk) begin
    if (avm_rst) begin
      cnt_q <= '0;
      n_q <= '0;
      d_q <= '0;
      a_q <= '0;
      out_q <= '0;
    end else begin
      if (byte_done) cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (byte_done && state_q == S_READ_N) n_q <= {n_q[KEY_BITS-9:0], rx_byte};
      if (byte_done && state_q == S_READ_D) d_q <= {d_q[KEY_BITS-9:0], rx_byte};
      if (byte_done && state_q == S_READ_C) a_q <= {a_q[KEY_BITS-9:0], rx_byte};
      if (state_q == S_WAIT && i_core_finished) out_q <= i_core_result[KEY_BITS-9:0];
      if (byte_done && is_tx) out_q <= out_q << 8;
      if (byte_done && is_tx && last && KEEP_KEY == 0) begin
        n_q <= '0;
        d_q <= '0;
      end
    end
  end
endmodule
